// File: rtl/ldpc_pkg.sv
// Shared types for the LDPC iteration scheduler: FSM state encoding,
// engine phase ids, default widths/limits and a state->phase decoder.
package ldpc_pkg;

    localparam int ITER_W_DEF     = 4;
    localparam int WDOG_W_DEF     = 12;
    localparam int WDOG_LIMIT_DEF = 4000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CNP   = 3'd2,
        ST_GAP_C = 3'd3,
        ST_VNP   = 3'd4,
        ST_GAP_V = 3'd5,
        ST_OUT   = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // Which engine owns the message RAM in a given state.
    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH_LOAD = 3'd1,
        PH_CNP  = 3'd2,
        PH_VNP  = 3'd3,
        PH_OUT  = 3'd4
    } phase_e;

    function automatic phase_e phase_of(input state_e s);
        phase_e p;
        case (s)
            ST_LOAD: p = PH_LOAD;
            ST_CNP:  p = PH_CNP;
            ST_VNP:  p = PH_VNP;
            ST_OUT:  p = PH_OUT;
            default: p = PH_NONE;
        endcase
        return p;
    endfunction

    function automatic logic is_run(input state_e s);
        return phase_of(s) != PH_NONE;
    endfunction

endpackage

// File: rtl/ldpc_phase_wdog.sv
// Per-phase watchdog: saturating cycle counter with clear/enable.
// Ports: clk, rst (async high), clr (zero count), en (count this cycle),
//        expired (high during the WDOG_LIMIT-th counted cycle and after).
module ldpc_phase_wdog #(
    parameter int WDOG_W     = 12,
    parameter int WDOG_LIMIT = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIM    = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LIM_M1 = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q holds cycles already spent, so the current cycle is the
    // LIMIT-th one when cnt_q reaches LIMIT-1.
    assign expired = (cnt_q >= LIM_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration scheduler: LOAD -> (CNP -> VNP) x max -> OUT -> DONE,
// handing the shared message RAM to one engine at a time.
// Ports: clk, rst (async high), ce (global enable; gates *_on and dec_done),
//   frame_start/ready/cfg_max_iter (frame request), <eng>_on/<eng>_finish
//   for load/cnp/vnp/out engines, parity_ok (with vnp_finish),
//   iter_cnt, dec_done/dec_ok/dec_err (frame result).
// Build option: EARLY_TERM_EN stops iterating once parity is satisfied.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int ITER_W     = ITER_W_DEF,
    parameter int WDOG_W     = WDOG_W_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              frame_start,
    output logic              ready,
    input  logic [ITER_W-1:0] cfg_max_iter,
    output logic              load_on,
    input  logic              load_finish,
    output logic              cnp_on,
    input  logic              cnp_finish,
    output logic              vnp_on,
    input  logic              vnp_finish,
    input  logic              parity_ok,
    output logic              out_on,
    input  logic              out_finish,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              dec_done,
    output logic              dec_ok,
    output logic              dec_err
);

    localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              load_on_q, load_on_d;
    logic              cnp_on_q, cnp_on_d;
    logic              vnp_on_q, vnp_on_d;
    logic              out_on_q, out_on_d;
    logic              fin;
    logic              expired;
    logic              early_stop;

`ifdef EARLY_TERM_EN
    assign early_stop = ok_q;
`else
    assign early_stop = 1'b0;
`endif

    ldpc_phase_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (ce && (state_d != state_q)),
        .en      (ce && is_run(state_q)),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        max_d   = max_q;
        ok_d    = ok_q;
        err_d   = err_q;
        fin     = 1'b0;
        if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_d = ST_LOAD;
                        max_d   = (cfg_max_iter == '0) ? ONE : cfg_max_iter;
                        iter_d  = '0;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_LOAD: begin
                    fin = load_finish;
                    if (fin) state_d = ST_CNP;
                end
                ST_CNP: begin
                    fin = cnp_finish;
                    if (fin) state_d = ST_GAP_C;
                end
                ST_GAP_C: state_d = ST_VNP;
                ST_VNP: begin
                    fin = vnp_finish;
                    if (fin) begin
                        state_d = ST_GAP_V;
                        iter_d  = iter_q + ONE;
                        ok_d    = parity_ok;
                    end
                end
                ST_GAP_V: begin
                    if ((iter_q == max_q) || early_stop) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_CNP;
                    end
                end
                ST_OUT: begin
                    fin = out_finish;
                    if (fin) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // A finish arriving on the expiry cycle still completes the phase.
            if (is_run(state_q) && !fin && expired) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
                ok_d    = 1'b0;
            end
        end
    end

    // Registered outputs decode the next state so enables are high from
    // the first cycle of a phase and low the cycle after its finish.
    always_comb begin
        load_on_d = (phase_of(state_d) == PH_LOAD);
        cnp_on_d  = (phase_of(state_d) == PH_CNP);
        vnp_on_d  = (phase_of(state_d) == PH_VNP);
        out_on_d  = (phase_of(state_d) == PH_OUT);
        done_d    = (state_d == ST_DONE);
        ready_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            max_q     <= ONE;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            load_on_q <= 1'b0;
            cnp_on_q  <= 1'b0;
            vnp_on_q  <= 1'b0;
            out_on_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            max_q     <= max_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            load_on_q <= load_on_d;
            cnp_on_q  <= cnp_on_d;
            vnp_on_q  <= vnp_on_d;
            out_on_q  <= out_on_d;
        end
    end

    assign ready    = ready_q;
    assign load_on  = load_on_q & ce;
    assign cnp_on   = cnp_on_q & ce;
    assign vnp_on   = vnp_on_q & ce;
    assign out_on   = out_on_q & ce;
    assign dec_done = done_q & ce;
    assign iter_cnt = iter_q;
    assign dec_ok   = ok_q;
    assign dec_err  = err_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed self-checking bench for ldpc_iter_ctrl with behavioural
// load/cnp/vnp/out engines; watchdog limit shortened to 100 cycles.
module tb_ldpc_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst, ce, frame_start;
    logic [3:0] cfg_max_iter;
    logic       load_finish, cnp_finish, vnp_finish, parity_ok, out_finish;
    logic       ready, load_on, cnp_on, vnp_on, out_on;
    logic       dec_done, dec_ok, dec_err;
    logic [3:0] iter_cnt;

    int n_chk = 0;
    int n_pass = 0;

    int lat_l, lat_c, lat_v, lat_o;
    logic [15:0] par_mask;
    int cl, cc, cv, co, vnp_idx;

    int n_load, n_cnp, n_vnp, n_out, cnp_cyc, idle, overlap;
    int done_cnt, ready_bad, ce_bad, ce_at;
    logic inj;
    logic r_ok, r_err, post_ready, post_done;
    logic [3:0] r_it;

    ldpc_iter_ctrl #(
        .ITER_W     (4),
        .WDOG_W     (12),
        .WDOG_LIMIT (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .frame_start  (frame_start),
        .ready        (ready),
        .cfg_max_iter (cfg_max_iter),
        .load_on      (load_on),
        .load_finish  (load_finish),
        .cnp_on       (cnp_on),
        .cnp_finish   (cnp_finish),
        .vnp_on       (vnp_on),
        .vnp_finish   (vnp_finish),
        .parity_ok    (parity_ok),
        .out_on       (out_on),
        .out_finish   (out_finish),
        .iter_cnt     (iter_cnt),
        .dec_done     (dec_done),
        .dec_ok       (dec_ok),
        .dec_err      (dec_err)
    );

    always #5 clk = ~clk;

    task automatic eng_reset();
        cl = 0; cc = 0; cv = 0; co = 0; vnp_idx = 0;
        load_finish = 0; cnp_finish = 0; vnp_finish = 0;
        out_finish = 0; parity_ok = 0;
    endtask

    // Engines count enabled cycles, raise finish at their latency (0 = never)
    // and drop it once their enable goes low.
    task automatic eng_step();
        if (load_on) begin
            cl++;
            if (lat_l != 0 && cl >= lat_l) load_finish = 1;
        end else begin
            cl = 0; load_finish = 0;
        end
        if (cnp_on) begin
            cc++;
            if (lat_c != 0 && cc >= lat_c) cnp_finish = 1;
        end else begin
            cc = 0; cnp_finish = 0;
        end
        if (vnp_on) begin
            cv++;
            if (lat_v != 0 && cv >= lat_v) begin
                vnp_finish = 1;
                parity_ok = par_mask[vnp_idx];
            end
        end else begin
            if (vnp_finish) vnp_idx++;
            cv = 0; vnp_finish = 0; parity_ok = 0;
        end
        if (out_on) begin
            co++;
            if (lat_o != 0 && co >= lat_o) out_finish = 1;
        end else begin
            co = 0; out_finish = 0;
        end
    endtask

    task automatic start_frame(input logic [3:0] m);
        @(negedge clk);
        cfg_max_iter = m;
        frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
    endtask

    task automatic run_frame(input int max_cyc);
        logic pl, pc, pv, po, seen;
        logic [3:0] it_hold;
        int off_left;
        n_load = 0; n_cnp = 0; n_vnp = 0; n_out = 0; cnp_cyc = 0;
        idle = 0; overlap = 0; done_cnt = 0; ready_bad = 0; ce_bad = 0;
        pl = 0; pc = 0; pv = 0; po = 0; seen = 0; off_left = 0;
        it_hold = 0;
        for (int cyc = 0; cyc < max_cyc && !seen; cyc++) begin
            @(negedge clk);
            if (!ce) begin
                if (load_on | cnp_on | vnp_on | out_on | dec_done) ce_bad++;
                if (iter_cnt !== it_hold) ce_bad++;
            end else begin
                if (load_on && !pl) n_load++;
                if (cnp_on && !pc) n_cnp++;
                if (vnp_on && !pv) n_vnp++;
                if (out_on && !po) n_out++;
                if (cnp_on) cnp_cyc++;
                if (int'(load_on) + int'(cnp_on) + int'(vnp_on) + int'(out_on) > 1)
                    overlap++;
                if (!ready && !load_on && !cnp_on && !vnp_on && !out_on && !dec_done)
                    idle++;
            end
            if (ready) ready_bad++;
            if (dec_done) begin
                done_cnt++; r_ok = dec_ok; r_err = dec_err; r_it = iter_cnt; seen = 1;
            end
            pl = load_on; pc = cnp_on; pv = vnp_on; po = out_on;
            frame_start = 0;
            if (inj && n_cnp == 1 && cnp_cyc == 5) begin
                frame_start = 1; cfg_max_iter = 4'd5;
            end
            eng_step();
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) ce = 1;
            end else if (ce_at > 0 && cnp_cyc == ce_at) begin
                ce = 0; off_left = 10; it_hold = iter_cnt; ce_at = 0;
            end
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL frame_timeout: no dec_done within %0d cycles", max_cyc);
        end
        @(negedge clk);
        post_ready = ready;
        post_done = dec_done;
    endtask

    task automatic setup(input int l, input int c, input int v, input int o,
                         input logic [15:0] m);
        lat_l = l; lat_c = c; lat_v = v; lat_o = o; par_mask = m;
        inj = 0; ce_at = 0;
        eng_reset();
    endtask

    task automatic test_reset();
        rst = 1; ce = 1; frame_start = 0; cfg_max_iter = 0;
        setup(10, 10, 10, 10, 16'h0);
        repeat (2) @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", ready); else n_pass++;
        n_chk++; if ({load_on, cnp_on, vnp_on, out_on} !== 4'b0)
            $display("FAIL rst_on: got %b exp 0000", {load_on, cnp_on, vnp_on, out_on}); else n_pass++;
        n_chk++; if (iter_cnt !== 4'd0) $display("FAIL rst_iter: got %0d exp 0", iter_cnt); else n_pass++;
        n_chk++; if ({dec_done, dec_ok, dec_err} !== 3'b0)
            $display("FAIL rst_flags: got %b exp 000", {dec_done, dec_ok, dec_err}); else n_pass++;
        rst = 0;
        repeat (2) @(negedge clk);
        n_chk++; if ({ready, load_on} !== 2'b10)
            $display("FAIL idle_hold: got %b exp 10", {ready, load_on}); else n_pass++;
    endtask

    task automatic test_basic();
        setup(40, 40, 40, 40, 16'h0004);
        start_frame(4'd3);
        run_frame(2000);
        n_chk++; if (n_load != 1) $display("FAIL basic_load: got %0d exp 1", n_load); else n_pass++;
        n_chk++; if (n_cnp != 3) $display("FAIL basic_cnp: got %0d exp 3", n_cnp); else n_pass++;
        n_chk++; if (n_vnp != 3) $display("FAIL basic_vnp: got %0d exp 3", n_vnp); else n_pass++;
        n_chk++; if (n_out != 1) $display("FAIL basic_out: got %0d exp 1", n_out); else n_pass++;
        n_chk++; if (cnp_cyc != 120) $display("FAIL basic_cnp_cyc: got %0d exp 120", cnp_cyc); else n_pass++;
        n_chk++; if (idle != 6) $display("FAIL basic_gaps: got %0d exp 6", idle); else n_pass++;
        n_chk++; if (overlap != 0) $display("FAIL basic_overlap: got %0d exp 0", overlap); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL basic_done: got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (r_it !== 4'd3) $display("FAIL basic_iter: got %0d exp 3", r_it); else n_pass++;
        n_chk++; if (r_ok !== 1'b1) $display("FAIL basic_ok: got %b exp 1", r_ok); else n_pass++;
        n_chk++; if (r_err !== 1'b0) $display("FAIL basic_err: got %b exp 0", r_err); else n_pass++;
        n_chk++; if (ready_bad != 0) $display("FAIL basic_ready: got %0d exp 0", ready_bad); else n_pass++;
        n_chk++; if ({post_ready, post_done} !== 2'b10)
            $display("FAIL basic_post: got %b exp 10", {post_ready, post_done}); else n_pass++;
        n_chk++; if (dec_ok !== 1'b1) $display("FAIL basic_ok_hold: got %b exp 1", dec_ok); else n_pass++;
    endtask

    task automatic test_early_term();
        int exp_it;
        logic exp_ok;
`ifdef EARLY_TERM_EN
        exp_it = 2; exp_ok = 1;
`else
        exp_it = 8; exp_ok = 0;
`endif
        setup(20, 20, 20, 20, 16'h0002);
        start_frame(4'd8);
        run_frame(3000);
        n_chk++; if (r_it !== 4'(exp_it)) $display("FAIL et_iter: got %0d exp %0d", r_it, exp_it); else n_pass++;
        n_chk++; if (n_cnp != exp_it) $display("FAIL et_cnp: got %0d exp %0d", n_cnp, exp_it); else n_pass++;
        n_chk++; if (r_ok !== exp_ok) $display("FAIL et_ok: got %b exp %b", r_ok, exp_ok); else n_pass++;
        n_chk++; if (n_out != 1) $display("FAIL et_out: got %0d exp 1", n_out); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL et_done: got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_max_zero();
        int stray;
        setup(15, 15, 15, 15, 16'h0001);
        inj = 1;
        start_frame(4'd0);
        run_frame(1000);
        n_chk++; if (r_it !== 4'd1) $display("FAIL mz_iter: got %0d exp 1", r_it); else n_pass++;
        n_chk++; if (n_cnp != 1) $display("FAIL mz_cnp: got %0d exp 1", n_cnp); else n_pass++;
        n_chk++; if (n_load != 1) $display("FAIL mz_load: got %0d exp 1", n_load); else n_pass++;
        n_chk++; if (ready_bad != 0) $display("FAIL mz_ready: got %0d exp 0", ready_bad); else n_pass++;
        n_chk++; if (r_ok !== 1'b1) $display("FAIL mz_ok: got %b exp 1", r_ok); else n_pass++;
        n_chk++; if (post_ready !== 1'b1) $display("FAIL mz_post: got %b exp 1", post_ready); else n_pass++;
        inj = 0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (load_on || !ready || dec_done) stray++;
        end
        n_chk++; if (stray != 0) $display("FAIL mz_no_queue: got %0d exp 0", stray); else n_pass++;
    endtask

    task automatic test_watchdog();
        setup(10, 0, 10, 10, 16'h0);
        start_frame(4'd2);
        run_frame(1000);
        n_chk++; if (cnp_cyc != 100) $display("FAIL wd_cnp_cyc: got %0d exp 100", cnp_cyc); else n_pass++;
        n_chk++; if (r_err !== 1'b1) $display("FAIL wd_err: got %b exp 1", r_err); else n_pass++;
        n_chk++; if (r_ok !== 1'b0) $display("FAIL wd_ok: got %b exp 0", r_ok); else n_pass++;
        n_chk++; if (n_out != 0) $display("FAIL wd_out: got %0d exp 0", n_out); else n_pass++;
        n_chk++; if (n_vnp != 0) $display("FAIL wd_vnp: got %0d exp 0", n_vnp); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL wd_done: got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (r_it !== 4'd0) $display("FAIL wd_iter: got %0d exp 0", r_it); else n_pass++;
        n_chk++; if (post_ready !== 1'b1) $display("FAIL wd_post: got %b exp 1", post_ready); else n_pass++;
    endtask

    task automatic test_rst_mid_vnp();
        logic found;
        setup(20, 20, 20, 20, 16'h0);
        start_frame(4'd3);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            eng_step();
            if (vnp_idx == 1 && cv == 5) found = 1;
        end
        n_chk++; if (!found) $display("FAIL rv_reach: got 0 exp 1"); else n_pass++;
        n_chk++; if ({vnp_on, iter_cnt} !== 5'b1_0001)
            $display("FAIL rv_pre: got %b exp 10001", {vnp_on, iter_cnt}); else n_pass++;
        #2 rst = 1;
        #1;
        n_chk++; if (vnp_on !== 1'b0) $display("FAIL rv_vnp_on: got %b exp 0", vnp_on); else n_pass++;
        n_chk++; if (ready !== 1'b1) $display("FAIL rv_ready: got %b exp 1", ready); else n_pass++;
        n_chk++; if (iter_cnt !== 4'd0) $display("FAIL rv_iter: got %0d exp 0", iter_cnt); else n_pass++;
        n_chk++; if (dec_err !== 1'b0) $display("FAIL rv_err: got %b exp 0", dec_err); else n_pass++;
        @(negedge clk);
        rst = 0;
        eng_reset();
        start_frame(4'd2);
        run_frame(1000);
        n_chk++; if (r_it !== 4'd2) $display("FAIL rv_next_iter: got %0d exp 2", r_it); else n_pass++;
        n_chk++; if (n_cnp != 2) $display("FAIL rv_next_cnp: got %0d exp 2", n_cnp); else n_pass++;
        n_chk++; if ({done_cnt == 1, r_err} !== 2'b10)
            $display("FAIL rv_next_done: got %b exp 10", {done_cnt == 1, r_err}); else n_pass++;
    endtask

    task automatic test_ce_freeze();
        setup(10, 65, 10, 10, 16'h0);
        ce_at = 30;
        start_frame(4'd1);
        run_frame(1000);
        n_chk++; if (cnp_cyc != 95) $display("FAIL ce_cnp_cyc: got %0d exp 95", cnp_cyc); else n_pass++;
        n_chk++; if (ce_bad != 0) $display("FAIL ce_gated: got %0d exp 0", ce_bad); else n_pass++;
        n_chk++; if (r_err !== 1'b0) $display("FAIL ce_wdog_frozen: got %b exp 0", r_err); else n_pass++;
        n_chk++; if (r_it !== 4'd1) $display("FAIL ce_iter: got %0d exp 1", r_it); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL ce_done: got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (ce !== 1'b1) $display("FAIL ce_restored: got %b exp 1", ce); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_term();
        test_max_zero();
        test_watchdog();
        test_rst_mid_vnp();
        test_ce_freeze();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
